// File: rtl/heap_arbiter.sv
// Two-port arbiter in front of a single heap memory: sequences each heap access
// and synthesises Add/Sub variants as a read followed by a write.
module heap_arbiter #(
  parameter int ADDRESS_BITS = 2,
  parameter int INDEX_BITS   = 1,
  parameter int DATA_BITS    = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [7:0]              req0_action,
  input  logic [ADDRESS_BITS-1:0] req0_array,
  input  logic [INDEX_BITS-1:0]   req0_index,
  input  logic [DATA_BITS-1:0]    req0_in,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [7:0]              req1_action,
  input  logic [ADDRESS_BITS-1:0] req1_array,
  input  logic [INDEX_BITS-1:0]   req1_index,
  input  logic [DATA_BITS-1:0]    req1_in,
  output logic                    rsp0_valid,
  output logic [DATA_BITS-1:0]    rsp0_out,
  output logic [31:0]             rsp0_error,
  output logic                    rsp1_valid,
  output logic [DATA_BITS-1:0]    rsp1_out,
  output logic [31:0]             rsp1_error,
  output logic                    heapClock,
  output logic [7:0]              heapAction,
  output logic [ADDRESS_BITS-1:0] heapArray,
  output logic [INDEX_BITS-1:0]   heapIndex,
  output logic [DATA_BITS-1:0]    heapIn,
  input  logic [DATA_BITS-1:0]    heapOut,
  input  logic [31:0]             heapError
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CHECK   = 3'd1;
  localparam logic [2:0] STROBE1 = 3'd2;
  localparam logic [2:0] SAMPLE1 = 3'd3;
  localparam logic [2:0] STROBE2 = 3'd4;
  localparam logic [2:0] SAMPLE2 = 3'd5;
  localparam logic [2:0] RESPOND = 3'd6;

  localparam logic [31:0] ILLEGAL_ERROR = 32'd10000280;

  logic [2:0]              state;
  logic                    last;
  logic                    owner;
  logic                    grant;
  logic                    accept;
  logic [7:0]              op_action;
  logic [ADDRESS_BITS-1:0] op_array;
  logic [INDEX_BITS-1:0]   op_index;
  logic [DATA_BITS-1:0]    op_in;
  logic [DATA_BITS-1:0]    old_value;
  logic [DATA_BITS-1:0]    new_value;
  logic [DATA_BITS-1:0]    rmw_sum;
  logic                    is_basic, is_rmw, is_add, is_after;
  logic                    finish;
  logic [DATA_BITS-1:0]    fin_out;
  logic [31:0]             fin_error;

  always_comb begin
    is_basic = (op_action >= 8'd1) && (op_action <= 8'd4);
    is_rmw   = (op_action >= 8'd20) && (op_action <= 8'd23);
    is_add   = (op_action == 8'd20) || (op_action == 8'd21);
    is_after = (op_action == 8'd21) || (op_action == 8'd23);
    rmw_sum  = is_add ? (heapOut + op_in) : (heapOut - op_in);

    // On a tie the requester that was not served last wins.
    grant      = (req0_valid && req1_valid) ? ~last : req1_valid;
    req0_ready = (state == IDLE) && req0_valid && !grant;
    req1_ready = (state == IDLE) && req1_valid && grant;
    accept     = req0_ready || req1_ready;

    finish    = 1'b0;
    fin_out   = '0;
    fin_error = '0;
    case (state)
      CHECK: if (!is_basic && !is_rmw) begin
        finish    = 1'b1;
        fin_error = ILLEGAL_ERROR;
      end
      SAMPLE1: if (!is_rmw || heapError != 32'd0) begin
        finish    = 1'b1;
        fin_out   = is_rmw ? '0 : heapOut;
        fin_error = heapError;
      end
      SAMPLE2: begin
        finish    = 1'b1;
        fin_out   = is_after ? old_value : new_value;
        fin_error = heapError;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last       <= 1'b1;
      owner      <= 1'b0;
      op_action  <= '0;
      op_array   <= '0;
      op_index   <= '0;
      op_in      <= '0;
      old_value  <= '0;
      new_value  <= '0;
      heapClock  <= 1'b0;
      heapAction <= '0;
      heapArray  <= '0;
      heapIndex  <= '0;
      heapIn     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          owner     <= grant;
          last      <= grant;
          op_action <= grant ? req1_action : req0_action;
          op_array  <= grant ? req1_array  : req0_array;
          op_index  <= grant ? req1_index  : req0_index;
          op_in     <= grant ? req1_in     : req0_in;
          state     <= CHECK;
        end
        CHECK: begin
          if (is_basic || is_rmw) begin
            heapAction <= is_rmw ? 8'd3 : op_action;
            heapArray  <= op_array;
            heapIndex  <= op_index;
            if (is_basic) heapIn <= op_in;
            state <= STROBE1;
          end else begin
            state <= RESPOND;
          end
        end
        STROBE1: begin
          heapClock <= ~heapClock;
          state     <= SAMPLE1;
        end
        SAMPLE1: begin
          old_value <= heapOut;
          new_value <= rmw_sum;
          if (is_rmw && heapError == 32'd0) begin
            heapAction <= 8'd2;
            heapIn     <= rmw_sum;
            state      <= STROBE2;
          end else begin
            state <= RESPOND;
          end
        end
        STROBE2: begin
          heapClock <= ~heapClock;
          state     <= SAMPLE2;
        end
        SAMPLE2: state <= RESPOND;
        default: state <= IDLE;
      endcase
    end
  end

  // Response registers load on the way into RESPOND so the strobe and data coincide.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp0_valid <= 1'b0;
      rsp0_out   <= '0;
      rsp0_error <= '0;
      rsp1_valid <= 1'b0;
      rsp1_out   <= '0;
      rsp1_error <= '0;
    end else begin
      rsp0_valid <= finish && !owner;
      rsp1_valid <= finish && owner;
      if (finish && !owner) begin
        rsp0_out   <= fin_out;
        rsp0_error <= fin_error;
      end
      if (finish && owner) begin
        rsp1_out   <= fin_out;
        rsp1_error <= fin_error;
      end
    end
  end

endmodule

// File: tb/tb_heap_arbiter.sv
// Directed bench for heap_arbiter with a small behavioural heap model.
module tb_heap_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_action = '0, req1_action = '0;
  logic [1:0]  req0_array = '0, req1_array = '0;
  logic [0:0]  req0_index = '0, req1_index = '0;
  logic [11:0] req0_in = '0, req1_in = '0;
  logic        rsp0_valid, rsp1_valid;
  logic [11:0] rsp0_out, rsp1_out;
  logic [31:0] rsp0_error, rsp1_error;
  logic        heapClock;
  logic [7:0]  heapAction;
  logic [1:0]  heapArray;
  logic [0:0]  heapIndex;
  logic [11:0] heapIn;
  logic [11:0] heapOut = '0;
  logic [31:0] heapError = '0;

  int passed = 0;
  int total = 0;
  int heap_toggles = 0;
  int wrong_port = 0;
  logic [11:0] mem [0:3][0:1];

  heap_arbiter #(.ADDRESS_BITS(2), .INDEX_BITS(1), .DATA_BITS(12)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_action(req0_action),
    .req0_array(req0_array), .req0_index(req0_index), .req0_in(req0_in),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_action(req1_action),
    .req1_array(req1_array), .req1_index(req1_index), .req1_in(req1_in),
    .rsp0_valid(rsp0_valid), .rsp0_out(rsp0_out), .rsp0_error(rsp0_error),
    .rsp1_valid(rsp1_valid), .rsp1_out(rsp1_out), .rsp1_error(rsp1_error),
    .heapClock(heapClock), .heapAction(heapAction), .heapArray(heapArray),
    .heapIndex(heapIndex), .heapIn(heapIn), .heapOut(heapOut), .heapError(heapError)
  );

  always #5 clock = ~clock;

  // Heap model: Reset=1, Write=2, Read=3, Size=4; reacts to every heapClock edge.
  always @(heapClock) begin
    if (reset === 1'b1) begin
      heap_toggles++;
      heapError = 32'd0;
      case (heapAction)
        8'd1: begin mem[heapArray][0] = '0; mem[heapArray][1] = '0; heapOut = '0; end
        8'd2: begin mem[heapArray][heapIndex] = heapIn; heapOut = heapIn; end
        8'd3: heapOut = mem[heapArray][heapIndex];
        8'd4: heapOut = 12'd2;
        default: begin heapOut = '0; heapError = 32'd1; end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input int port, input logic v, input logic [7:0] act,
                       input logic [1:0] arr, input logic idx, input logic [11:0] din);
    if (port == 0) begin
      req0_valid = v; req0_action = act; req0_array = arr; req0_index = idx; req0_in = din;
    end else begin
      req1_valid = v; req1_action = act; req1_array = arr; req1_index = idx; req1_in = din;
    end
  endtask

  // Issues one request (starting just after a negedge) and waits for its response.
  task automatic issue(input int port, input logic [7:0] act, input logic [1:0] arr,
                       input logic idx, input logic [11:0] din,
                       output int rdy_wait, output int lat);
    logic got;
    heap_toggles = 0;
    drive(port, 1'b1, act, arr, idx, din);
    rdy_wait = 0;
    #1;
    while (!((port == 0) ? req0_ready : req1_ready) && rdy_wait < 20) begin
      @(negedge clock); #1; rdy_wait++;
    end
    @(posedge clock); #1;
    if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clock);
      lat++;
      if ((port == 0) ? rsp0_valid : rsp1_valid) got = 1'b1;
      if ((port == 0) ? rsp1_valid : rsp0_valid) wrong_port++;
    end
    if (!got) lat = 99;
  endtask

  task automatic run(input string tag, input int port, input logic [7:0] act,
                     input logic [1:0] arr, input logic idx, input logic [11:0] din,
                     input logic [11:0] exp_out, input logic [31:0] exp_err,
                     input int exp_lat, input int exp_tog);
    int rw, lat;
    issue(port, act, arr, idx, din, rw, lat);
    $display("txn %s port=%0d act=%0d out=%03h err=%0d lat=%0d toggles=%0d",
             tag, port, act, (port == 0) ? rsp0_out : rsp1_out,
             (port == 0) ? rsp0_error : rsp1_error, lat, heap_toggles);
    check({tag, "_out"}, (port == 0) ? rsp0_out : rsp1_out, exp_out);
    check({tag, "_err"}, (port == 0) ? rsp0_error : rsp1_error, exp_err);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_tog"}, heap_toggles, exp_tog);
  endtask

  initial begin
    int rw, lat, n, tog_before;
    int rport [0:3];
    int rtime [0:3];
    logic [11:0] rout [0:3];
    int both_valid;

    for (int a = 0; a < 4; a++) begin mem[a][0] = '0; mem[a][1] = '0; end

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_heapClock", heapClock, 0);
    check("rst_heapAction", heapAction, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_out", rsp1_out, 0);
    check("rst_rsp0_error", rsp0_error, 0);
    reset = 1'b1;

    // First write: ready in the accept cycle, 4-cycle latency, one strobe
    issue(0, 8'd2, 2'd1, 1'b0, 12'h123, rw, lat);
    $display("txn write0 out=%03h err=%0d lat=%0d toggles=%0d", rsp0_out, rsp0_error, lat, heap_toggles);
    check("write0_ready_wait", rw, 0);
    check("write0_out", rsp0_out, 12'h123);
    check("write0_err", rsp0_error, 0);
    check("write0_lat", lat, 4);
    check("write0_tog", heap_toggles, 1);

    run("wr_ffe",    0, 8'd2,  2'd2, 1'b1, 12'hFFE, 12'hFFE, 0, 4, 1);
    run("add3",      1, 8'd20, 2'd2, 1'b1, 12'h003, 12'h001, 0, 6, 2);
    run("rd_after_add", 1, 8'd3, 2'd2, 1'b1, 12'h000, 12'h001, 0, 4, 1);
    run("addafter1", 1, 8'd21, 2'd2, 1'b1, 12'h001, 12'h001, 0, 6, 2);
    run("rd_after_addafter", 0, 8'd3, 2'd2, 1'b1, 12'h000, 12'h002, 0, 4, 1);
    run("wr_005",    1, 8'd2,  2'd2, 1'b1, 12'h005, 12'h005, 0, 4, 1);
    run("subafter7", 0, 8'd23, 2'd2, 1'b1, 12'h007, 12'h005, 0, 6, 2);
    run("rd_after_sub", 1, 8'd3, 2'd2, 1'b1, 12'h000, 12'hFFE, 0, 4, 1);
    run("size",      0, 8'd4,  2'd0, 1'b0, 12'h000, 12'h002, 0, 4, 1);
    run("illegal24", 0, 8'd24, 2'd2, 1'b1, 12'h001, 12'h000, 32'd10000280, 2, 0);
    check("wrong_port_none", wrong_port, 0);

    // Both requesters valid continuously after a fresh reset
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    drive(0, 1'b1, 8'd3, 2'd1, 1'b0, 12'h000);
    drive(1, 1'b1, 8'd3, 2'd2, 1'b1, 12'h000);
    #1;
    check("tie_ready0", req0_ready, 1);
    check("tie_ready1", req1_ready, 0);
    n = 0;
    both_valid = 0;
    for (int cyc = 1; cyc <= 40 && n < 4; cyc++) begin
      @(negedge clock);
      if (rsp0_valid && rsp1_valid) both_valid++;
      if (rsp0_valid) begin rport[n] = 0; rtime[n] = cyc; rout[n] = rsp0_out; n++; end
      else if (rsp1_valid) begin rport[n] = 1; rtime[n] = cyc; rout[n] = rsp1_out; n++; end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("alt_count", n, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < n) begin
        $display("txn alt%0d port=%0d cycle=%0d out=%03h", k, rport[k], rtime[k], rout[k]);
        check($sformatf("alt%0d_port", k), rport[k], k % 2);
        check($sformatf("alt%0d_out", k), rout[k], (k % 2 == 0) ? 12'h123 : 12'hFFE);
        check($sformatf("alt%0d_time", k), rtime[k], 4 + 5 * k);
      end
    end
    check("alt_both_valid", both_valid, 0);

    // Reset asserted during the write-back strobe of an Add
    run("wr_010", 1, 8'd2, 2'd3, 1'b0, 12'h010, 12'h010, 0, 4, 1);
    drive(0, 1'b1, 8'd20, 2'd3, 1'b0, 12'h005);
    rw = 0;
    #1;
    while (!req0_ready && rw < 20) begin @(negedge clock); #1; rw++; end
    @(posedge clock); #1;
    req0_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    check("pre_rst_action_write", heapAction, 2);
    tog_before = heap_toggles;
    reset = 1'b0;
    #1;
    check("mid_rst_heapClock", heapClock, 0);
    check("mid_rst_heapAction", heapAction, 0);
    check("mid_rst_heapIn", heapIn, 0);
    check("mid_rst_heapArray", heapArray, 0);
    check("mid_rst_rsp1_out", rsp1_out, 0);
    check("mid_rst_rsp0_valid", rsp0_valid, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("post_rst_no_toggle", heap_toggles, tog_before);
    check("post_rst_no_rsp", rsp0_valid | rsp1_valid, 0);

    drive(0, 1'b1, 8'd3, 2'd1, 1'b0, 12'h000);
    drive(1, 1'b1, 8'd3, 2'd3, 1'b0, 12'h000);
    #1;
    check("rst_tie_ready0", req0_ready, 1);
    check("rst_tie_ready1", req1_ready, 0);
    n = 0;
    for (int cyc = 1; cyc <= 30 && n < 2; cyc++) begin
      @(negedge clock);
      if (rsp0_valid) begin rport[n] = 0; rout[n] = rsp0_out; n++; end
      else if (rsp1_valid) begin rport[n] = 1; rout[n] = rsp1_out; n++; end
      if (n == 1) req0_valid = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("rst_tie_count", n, 2);
    if (n == 2) begin
      $display("txn rst_tie first=%0d out=%03h second=%0d out=%03h", rport[0], rout[0], rport[1], rout[1]);
      check("rst_tie_first_port", rport[0], 0);
      check("rst_tie_second_port", rport[1], 1);
      check("pre_add_value", rout[1], 12'h010);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/heap_arbiter.md
Name: heap_arbiter

Overview:
- Shares one heap Memory instance between two requesters using valid/ready request ports and one response port per requester.
- Sequences each heap access: set up fields, toggle heapClock, sample heapOut/heapError.
- Implements Add/AddAfter/Subtract/SubAfter as a two-access read-modify-write, because the heap only supports Reset/Write/Read/Size.
- Sits between the fpga program sequencer (or test benches) and the heap.

Parameters:
ADDRESS_BITS, 2, array-number width (matches heap)
INDEX_BITS, 1, index width (matches heap)
DATA_BITS, 12, element width (matches heap)

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-low reset
req0_valid / req1_valid  in  1  request present; held until accepted
req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
req0_action / req1_action  in  8  opcode (heap encoding)
req0_array / req1_array  in  ADDRESS_BITS  array number
req0_index / req1_index  in  INDEX_BITS  element index
req0_in / req1_in  in  DATA_BITS  write data or operand
rsp0_valid / rsp1_valid  out  1  one-cycle response strobe
rsp0_out / rsp1_out  out  DATA_BITS  result, held until next response on that port
rsp0_error / rsp1_error  out  32  error code, 0 = ok
heapClock  out  1  heap strobe; one transition per heap access
heapAction  out  8  to heap
heapArray  out  ADDRESS_BITS  to heap
heapIndex  out  INDEX_BITS  to heap
heapIn  out  DATA_BITS  to heap
heapOut  in  DATA_BITS  from heap
heapError  in  32  from heap

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, last=1 (requester 0 wins the first tie).
  - All outputs 0: heapClock, heap* fields, rsp*_valid, rsp*_out, rsp*_error.
  - An operation in flight is abandoned; no further heapClock transitions occur.
- Arbitration (IDLE only):
  - grant = the single valid requester; if both are valid, the requester != last.
  - reqK_ready = (state==IDLE) && grant==K, combinational. Ready is 0 in every other state.
  - On accept: latch action/array/index/in and the owner; set last=owner.
- States:
  - IDLE -> CHECK on accept.
  - CHECK: decode the latched opcode.
    - Opcode 1/2/3/4: drive heap fields from the latched request -> STROBE1.
    - Opcode 20-23: drive heapAction=3 (Read) with the same array/index -> STROBE1.
    - Any other opcode: result error=10000280, out=0 -> RESPOND, with no heapClock transition.
  - STROBE1: heapClock <= ~heapClock -> SAMPLE1.
  - SAMPLE1: capture heapOut as old and heapError.
    - Non-RMW: result out=old, error=heapError -> RESPOND.
    - RMW with heapError!=0: out=0, error=heapError, no write -> RESPOND.
    - RMW ok: new = old+in (20/21) or old-in (22/23), truncated modulo 2^DATA_BITS. Drive heapAction=2 (Write), heapIn=new -> STROBE2.
  - STROBE2: toggle heapClock -> SAMPLE2.
  - SAMPLE2: error=heapError. out=new for 20/22, out=old for 21/23 -> RESPOND.
  - RESPOND: rspK_valid=1 for exactly this cycle on the owner port only; rspK_out/rspK_error updated -> IDLE.
- Latency from the accept cycle to rsp_valid:
  - 4 cycles for Reset/Write/Read/Size.
  - 6 cycles for RMW ops.
  - 2 cycles for an illegal opcode.
- Throughput: one IDLE cycle between operations; no overlap or pipelining.
- Heap fields hold their last driven values between operations; only heapClock transitions trigger the heap.
- rsp*_valid never asserts on both ports in the same cycle.
- A requester whose valid stays high while it is being served is re-arbitrated in the next IDLE. With both requesters valid, grants alternate 0,1,0,1.
- Deasserting valid before ready is illegal (no check; behaviour undefined).

Test Plan:
- Reset released; req0 Write array1 index0 in=0x123 -> ready in cycle 0; rsp0_valid at cycle 4 with out=0x123, error=0; exactly 1 heapClock transition.
- Element holds 0xFFE; req1 Add in=3 -> rsp1 out=0x001 (wrapped); a following Read returns 0x001; 2 heapClock transitions. Repeat with AddAfter in=1 -> out=0x001 (old value), stored 0x002.
- Element holds 0x005; SubAfter in=7 -> out=0x005; a following Read returns 0xFFE.
- Both requesters valid continuously with Read ops -> grant order 0,1,0,1 after reset; each response only on the owning port; responses spaced 5 cycles apart.
- req0 action=24 (ShiftLeft) -> rsp0 out=0, error=10000280 at cycle 2; no heapClock transition.
- Assert reset low during STROBE2 of an Add -> all outputs 0 immediately; after release, req1 Read of that element returns the pre-Add value; heapClock=0; next tie grants requester 0.
